// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared state encoding and frame sizing for the SPI register sequencer
package spi_seq_pkg;
  typedef enum logic [2:0] {
    INIT_SEND,
    INIT_WAIT,
    INIT_DLY,
    IDLE,
    SEND,
    WAIT,
    RESP
  } seq_state_e;

  function automatic int frame_bytes(input int addr_bytes, input int data_bytes);
    return addr_bytes + data_bytes;
  endfunction
endpackage

// File: rtl/spi_init_rom.sv
// spi_init_rom: default power-up register table (address/data/post-write delay), zero-latency lookup
module spi_init_rom #(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 2,
  parameter int INIT_DEPTH = 10,
  parameter int DLY_W      = 16
) (
  input  logic [$clog2(INIT_DEPTH)-1:0] i_idx,
  output logic [ADDR_BYTES*8-1:0]       o_addr,
  output logic [DATA_BYTES*8-1:0]       o_data,
  output logic [DLY_W-1:0]              o_dly
);
  localparam int AW = ADDR_BYTES * 8;
  localparam int DW = DATA_BYTES * 8;
  localparam logic [15:0] ADDR_T [10] = '{16'h0030, 16'h00F9, 16'h0001, 16'h0002, 16'h0010,
                                          16'h0011, 16'h0020, 16'h0021, 16'h0040, 16'h0050};
  localparam logic [15:0] DATA_T [10] = '{16'h0001, 16'hC007, 16'h0000, 16'h0000, 16'h00FF,
                                          16'h0A0A, 16'h1234, 16'h0001, 16'h8000, 16'h0003};
  localparam logic [15:0] DLY_T  [10] = '{16'd0, 16'd20, 16'd4, 16'd0, 16'd8,
                                          16'd0, 16'd0, 16'd100, 16'd0, 16'd2};
  logic w_hit;
  assign w_hit  = int'(i_idx) < 10;
  assign o_addr = w_hit ? AW'(ADDR_T[i_idx]) : '0;
  assign o_data = w_hit ? DW'(DATA_T[i_idx]) : '0;
  assign o_dly  = w_hit ? DLY_W'(DLY_T[i_idx]) : '0;
endmodule

// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer: plays an init register table, then serves host read/write frames
// through a byte-level SPI master, assembling read data from MISO.
module spi_reg_sequencer
  import spi_seq_pkg::*;
#(
  parameter int ADDR_BYTES  = 2,
  parameter int DATA_BYTES  = 2,
  parameter int INIT_DEPTH  = 10,
  parameter int DLY_W       = 16,
  parameter int RD_FLAG_BIT = ADDR_BYTES * 8 - 1
) (
  input  logic                                         clk40M,
  input  logic                                         nRst,
  output logic [$clog2(INIT_DEPTH)-1:0]                init_idx,
  input  logic [ADDR_BYTES*8-1:0]                      init_addr,
  input  logic [DATA_BYTES*8-1:0]                      init_data,
  input  logic [DLY_W-1:0]                             init_dly,
  input  logic                                         restart_init,
  output logic                                         init_done,
  output logic                                         busy,
  input  logic                                         cmd_valid,
  output logic                                         cmd_ready,
  input  logic                                         cmd_rd,
  input  logic [ADDR_BYTES*8-1:0]                      cmd_addr,
  input  logic [DATA_BYTES*8-1:0]                      cmd_wdata,
  output logic                                         rd_valid,
  output logic [DATA_BYTES*8-1:0]                      rd_data,
  output logic [$clog2(ADDR_BYTES+DATA_BYTES+1)-1:0]   spi_tx_count,
  output logic [7:0]                                   spi_tx_byte,
  output logic                                         spi_tx_dv,
  input  logic                                         spi_tx_ready,
  input  logic [7:0]                                   spi_rx_byte,
  input  logic                                         spi_rx_dv
);
  localparam int AW = ADDR_BYTES * 8;
  localparam int DW = DATA_BYTES * 8;
  localparam int NB = frame_bytes(ADDR_BYTES, DATA_BYTES);
  localparam int CW = $clog2(NB + 1);
  localparam int IW = $clog2(INIT_DEPTH);
  seq_state_e r_state, w_next;
  logic [CW-1:0] r_byte_idx, r_rx_cnt;
  logic [DLY_W-1:0] r_dly;
  logic [IW-1:0] r_init_idx;
  logic [AW-1:0] r_addr, w_rd_addr;
  logic [DW-1:0] r_wdata, r_rd_data;
  logic [NB*8-1:0] w_frame, w_shift;
  logic r_ready_q, r_init_done, r_rd;
  logic w_done, w_last_byte, w_last_entry, w_init, w_adv, w_accept, w_restart, w_rx;
  assign w_done       = spi_tx_ready & ~r_ready_q;
  assign w_last_byte  = r_byte_idx == CW'(NB - 1);
  assign w_last_entry = r_init_idx == IW'(INIT_DEPTH - 1);
  assign w_init       = r_state inside {INIT_SEND, INIT_WAIT, INIT_DLY};
  assign w_adv        = (r_state == INIT_WAIT && w_done && w_last_byte && init_dly == '0) ||
                        (r_state == INIT_DLY && r_dly == DLY_W'(1));
  assign w_accept     = r_state == IDLE && cmd_valid && !restart_init;
  assign w_restart    = r_state == IDLE && restart_init;
  assign w_rx         = spi_rx_dv && r_rd && (r_state == SEND || r_state == WAIT);
  always_comb begin
    w_rd_addr = r_addr;
    w_rd_addr[RD_FLAG_BIT] = 1'b1;
  end
  // Frame is {data, addr} so that shifting right by 8*byte_idx yields bytes LSB-first.
  assign w_frame = w_init ? {init_data, init_addr}
                          : {r_rd ? {DW{1'b0}} : r_wdata, r_rd ? w_rd_addr : r_addr};
  assign w_shift = w_frame >> {r_byte_idx, 3'b000};
  always_ff @(posedge clk40M)
    r_state <= !nRst ? INIT_SEND : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT_SEND: w_next = INIT_WAIT;
      INIT_WAIT: w_next = !w_done ? INIT_WAIT : !w_last_byte ? INIT_SEND :
                          init_dly != '0 ? INIT_DLY : w_last_entry ? IDLE : INIT_SEND;
      INIT_DLY:  w_next = r_dly != DLY_W'(1) ? INIT_DLY : w_last_entry ? IDLE : INIT_SEND;
      IDLE:      w_next = restart_init ? INIT_SEND : cmd_valid ? SEND : IDLE;
      SEND:      w_next = WAIT;
      WAIT:      w_next = !w_done ? WAIT : !w_last_byte ? SEND : r_rd ? RESP : IDLE;
      RESP:      w_next = IDLE;
      default:   w_next = INIT_SEND;
    endcase
  end
  // Strobe is gated by nRst so a reset asserted mid-frame never leaves a byte pending.
  always_comb begin
    spi_tx_dv   = nRst && (r_state == INIT_SEND || r_state == SEND);
    spi_tx_byte = spi_tx_dv ? w_shift[7:0] : 8'h00;
    cmd_ready   = r_state == IDLE && !restart_init;
    busy        = r_state != IDLE;
    rd_valid    = r_state == RESP;
  end
  assign spi_tx_count = CW'(NB);
  assign init_idx     = r_init_idx;
  assign init_done    = r_init_done;
  assign rd_data      = r_rd_data;
  always_ff @(posedge clk40M)
    r_ready_q <= spi_tx_ready;
  always_ff @(posedge clk40M) begin
    if (!nRst) begin
      r_byte_idx  <= '0;
      r_rx_cnt    <= '0;
      r_dly       <= '0;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
      r_rd        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd_data   <= '0;
    end else begin
      if ((r_state == INIT_WAIT || r_state == WAIT) && w_done)
        r_byte_idx <= w_last_byte ? '0 : r_byte_idx + 1'b1;
      if (r_state == INIT_WAIT && w_done && w_last_byte)
        r_dly <= init_dly;
      else if (r_state == INIT_DLY)
        r_dly <= r_dly - 1'b1;
      if (w_adv) begin
        if (w_last_entry)
          r_init_done <= 1'b1;
        else
          r_init_idx <= r_init_idx + 1'b1;
      end
      if (w_restart) begin
        r_init_done <= 1'b0;
        r_init_idx  <= '0;
      end
      if (w_accept) begin
        r_rd     <= cmd_rd;
        r_addr   <= cmd_addr;
        r_wdata  <= cmd_wdata;
        r_rx_cnt <= '0;
      end
      if (w_rx) begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
        for (int i = 0; i < DATA_BYTES; i++)
          if (r_rx_cnt == CW'(ADDR_BYTES + i))
            r_rd_data[i*8 +: 8] <= spi_rx_byte;
      end
    end
  end
endmodule
